dut_initiator: RTL and testbench

DUT_INITIATOR -- requirements
Module: dut_initiator

---
 rtl/dut_initiator_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/dut_initiator.sv | 175 +++++++++++++++++
 tb/tb_dut_initiator.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_initiator_pkg.sv
// Shared types and constants for the DUT initiator.
//   pkt_state_t : packet FSM (IDLE -> SEND_LEN -> SEND_DATA)
//   cfg_state_t : config request FSM (C_IDLE -> C_ISSUE)
//   CFG_READ / CFG_WRITE : encoding of the config op bit
//   DATA_W / ADDR_W / CFG_W : byte, config address and config data widths
package dut_initiator_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CFG_W  = 32;

  localparam logic CFG_READ  = 1'b0;
  localparam logic CFG_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_LEN  = 2'd1,
    SEND_DATA = 2'd2
  } pkt_state_t;

  typedef enum logic {
    C_IDLE  = 1'b0,
    C_ISSUE = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-based full/empty flags.
//   clk, rst          : clock, asynchronous active-high reset (pointers/count only)
//   push, push_data   : write request; ignored while full
//   pop, head         : read request (ignored while empty); head is the oldest entry
//   full, empty       : occupancy flags
// Push and pop in the same cycle both take effect and leave the count unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; emptiness is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dut_initiator.sv
// Host-side initiator that drives a DUT's method interface.
//   Host side : host_len_* (packet length push), host_byte_* (payload push into
//               a byte FIFO), host_cfg_* (config read/write request),
//               host_rsp_* (config read data), res_* (captured dout results).
//   DUT side  : len_* and din_* (packet calls), dout_* (result drain),
//               cfg_* (config actionvalue call).
// Every DUT-side *_en is only raised while the matching *_rdy is high; the call
// fires on that rising edge. Packet, config and dout paths run independently.
module dut_initiator
  import dut_initiator_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] host_len_value,
  input  logic              host_len_en,
  output logic              host_len_rdy,
  input  logic [DATA_W-1:0] host_byte_value,
  input  logic              host_byte_en,
  output logic              host_byte_rdy,
  input  logic [ADDR_W-1:0] host_cfg_address,
  input  logic [CFG_W-1:0]  host_cfg_data,
  input  logic              host_cfg_op,
  input  logic              host_cfg_en,
  output logic              host_cfg_rdy,
  output logic [CFG_W-1:0]  host_rsp_value,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] len_value,
  output logic              len_en,
  input  logic              len_rdy,
  output logic [DATA_W-1:0] din_value,
  output logic              din_en,
  input  logic              din_rdy,
  input  logic [DATA_W-1:0] dout_value,
  output logic              dout_en,
  input  logic              dout_rdy,
  output logic [ADDR_W-1:0] cfg_address,
  output logic [CFG_W-1:0]  cfg_data_in,
  output logic              cfg_op,
  output logic              cfg_en,
  input  logic [CFG_W-1:0]  cfg_data_out,
  input  logic              cfg_rdy,
  output logic [DATA_W-1:0] res_value,
  output logic              res_valid,
  input  logic              res_ack
);

  pkt_state_t        state, state_n;
  logic [DATA_W-1:0] remaining, remaining_n;
  cfg_state_t        cstate, cstate_n;
  logic [ADDR_W-1:0] cfg_addr_q;
  logic [CFG_W-1:0]  cfg_data_q;
  logic              cfg_op_q;
  logic              fifo_full;
  logic              fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (host_byte_en),
    .push_data (host_byte_value),
    .pop       (din_en),
    .head      (din_value),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign host_byte_rdy = !fifo_full;

  // The remaining counter still holds the full length while in SEND_LEN.
  assign len_value = remaining;

  always_comb begin
    state_n      = state;
    remaining_n  = remaining;
    host_len_rdy = 1'b0;
    len_en       = 1'b0;
    din_en       = 1'b0;
    case (state)
      IDLE: begin
        host_len_rdy = 1'b1;
        if (host_len_en) begin
          remaining_n = host_len_value;
          state_n     = SEND_LEN;
        end
      end
      SEND_LEN: begin
        len_en = len_rdy;
        if (len_rdy) state_n = (remaining != '0) ? SEND_DATA : IDLE;
      end
      SEND_DATA: begin
        din_en = din_rdy && !fifo_empty;
        if (din_en) begin
          remaining_n = remaining - DATA_W'(1);
          if (remaining == DATA_W'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
    end
  end

  // dout drain: the result slot can accept a new value when it is empty or
  // being acknowledged in the same cycle. Reset is folded in because this
  // enable is not derived from a resettable state register.
  assign dout_en = !rst && dout_rdy && (!res_valid || res_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_value <= '0;
    end else if (dout_en) begin
      res_valid <= 1'b1;
      res_value <= dout_value;
    end else if (res_ack) begin
      res_valid <= 1'b0;
    end
  end

  always_comb begin
    cstate_n     = cstate;
    host_cfg_rdy = 1'b0;
    cfg_en       = 1'b0;
    case (cstate)
      C_IDLE: begin
        host_cfg_rdy = 1'b1;
        if (host_cfg_en) cstate_n = C_ISSUE;
      end
      C_ISSUE: begin
        cfg_en = cfg_rdy;
        if (cfg_rdy) cstate_n = C_IDLE;
      end
      default: cstate_n = C_IDLE;
    endcase
  end

  assign cfg_address = cfg_addr_q;
  assign cfg_data_in = cfg_data_q;
  assign cfg_op      = cfg_op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cstate         <= C_IDLE;
      cfg_addr_q     <= '0;
      cfg_data_q     <= '0;
      cfg_op_q       <= CFG_READ;
      host_rsp_valid <= 1'b0;
      host_rsp_value <= '0;
    end else begin
      cstate <= cstate_n;
      if (host_cfg_en && host_cfg_rdy) begin
        cfg_addr_q <= host_cfg_address;
        cfg_data_q <= host_cfg_data;
        cfg_op_q   <= host_cfg_op;
      end
      // Only a read call returns data; the valid is a one-cycle pulse.
      host_rsp_valid <= cfg_en && (cfg_op_q == CFG_READ);
      if (cfg_en && (cfg_op_q == CFG_READ)) host_rsp_value <= cfg_data_out;
    end
  end

endmodule

// File: tb/tb_dut_initiator.sv
// Scoreboard bench for dut_initiator: host-side tasks push expected traffic into
// queues, a negedge monitor pops and compares whenever the DUT fires a call.
module tb_dut_initiator;
  import dut_initiator_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  host_len_value = '0, host_byte_value = '0, host_cfg_address = '0;
  logic        host_len_en = 1'b0, host_byte_en = 1'b0, host_cfg_en = 1'b0, host_cfg_op = 1'b0;
  logic [31:0] host_cfg_data = '0;
  logic        host_len_rdy, host_byte_rdy, host_cfg_rdy, host_rsp_valid;
  logic [31:0] host_rsp_value;
  logic [7:0]  len_value, din_value, res_value, cfg_address;
  logic        len_en, din_en, dout_en, cfg_en, cfg_op, res_valid;
  logic        len_rdy = 1'b0, din_rdy = 1'b0, dout_rdy = 1'b0, cfg_rdy = 1'b0, res_ack = 1'b0;
  logic [7:0]  dout_value = '0;
  logic [31:0] cfg_data_in;
  logic [31:0] cfg_data_out = '0;

  dut_initiator #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .host_len_value(host_len_value), .host_len_en(host_len_en), .host_len_rdy(host_len_rdy),
    .host_byte_value(host_byte_value), .host_byte_en(host_byte_en), .host_byte_rdy(host_byte_rdy),
    .host_cfg_address(host_cfg_address), .host_cfg_data(host_cfg_data), .host_cfg_op(host_cfg_op),
    .host_cfg_en(host_cfg_en), .host_cfg_rdy(host_cfg_rdy),
    .host_rsp_value(host_rsp_value), .host_rsp_valid(host_rsp_valid),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_value(dout_value), .dout_en(dout_en), .dout_rdy(dout_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op), .cfg_en(cfg_en),
    .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy),
    .res_value(res_value), .res_valid(res_valid), .res_ack(res_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [7:0] a; logic [31:0] d; logic op; } cfg_t;

  int          total = 0, bad = 0;
  logic [7:0]  exp_len[$], exp_din[$], exp_res[$];
  logic [31:0] exp_rsp[$];
  cfg_t        exp_cfg[$];
  int          din_cyc[$], len_cyc[$];
  int          credits = 0, len_fires = 0, din_fires = 0, dout_fires = 0, cfg_fires = 0, rsp_seen = 0;
  int          host_len_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: sample between edges; outputs seen here fire on the next edge.
  always @(negedge clk) begin
    logic [7:0] e8;
    cfg_t       ec;
    if (!rst) begin
      if (host_rsp_valid) begin
        rsp_seen++;
        chk("rsp_expected", 32'(exp_rsp.size() > 0), 1);
        if (exp_rsp.size() > 0) chk("rsp_value", host_rsp_value, exp_rsp.pop_front());
      end
      if (res_valid && res_ack) begin
        chk("res_expected", 32'(exp_res.size() > 0), 1);
        if (exp_res.size() > 0) chk("res_value", 32'(res_value), 32'(exp_res.pop_front()));
      end
      chk("dout_en_rule", 32'(dout_en), 32'(dout_rdy && (!res_valid || res_ack)));
      if (dout_en) begin
        exp_res.push_back(dout_value);
        dout_fires++;
      end
      if (len_en) begin
        chk("len_rdy_rule", 32'(len_rdy), 1);
        chk("len_expected", 32'(exp_len.size() > 0), 1);
        if (exp_len.size() > 0) begin
          e8 = exp_len.pop_front();
          chk("len_value", 32'(len_value), 32'(e8));
          credits += int'(e8);
        end
        len_fires++;
        len_cyc.push_back(cyc + 1);
      end
      if (din_en) begin
        chk("din_rdy_rule", 32'(din_rdy), 1);
        chk("din_allowed", 32'(credits > 0 && exp_din.size() > 0), 1);
        if (credits > 0 && exp_din.size() > 0) begin
          chk("din_value", 32'(din_value), 32'(exp_din.pop_front()));
          credits--;
        end
        din_fires++;
        din_cyc.push_back(cyc + 1);
      end
      if (cfg_en) begin
        chk("cfg_rdy_rule", 32'(cfg_rdy), 1);
        chk("cfg_expected", 32'(exp_cfg.size() > 0), 1);
        if (exp_cfg.size() > 0) begin
          ec = exp_cfg.pop_front();
          chk("cfg_address", 32'(cfg_address), 32'(ec.a));
          chk("cfg_op", 32'(cfg_op), 32'(ec.op));
          if (ec.op == CFG_WRITE) chk("cfg_data_in", cfg_data_in, ec.d);
          else exp_rsp.push_back(cfg_data_out);
        end
        cfg_fires++;
      end
    end
  end

  // Host tasks: called and return just after a rising edge.
  task automatic push_len(input logic [7:0] v);
    int n = 0;
    host_len_value = v;
    host_len_en    = 1'b1;
    @(negedge clk);
    while (!host_len_rdy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) expired("push_len");
    else begin exp_len.push_back(v); host_len_edge = cyc + 1; end
    @(posedge clk); #1;
    host_len_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    int n = 0;
    host_byte_value = v;
    host_byte_en    = 1'b1;
    @(negedge clk);
    while (!host_byte_rdy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) expired("push_byte");
    else exp_din.push_back(v);
    @(posedge clk); #1;
    host_byte_en = 1'b0;
  endtask

  task automatic push_cfg(input logic [7:0] a, input logic [31:0] d, input logic op);
    int n = 0;
    host_cfg_address = a;
    host_cfg_data    = d;
    host_cfg_op      = op;
    host_cfg_en      = 1'b1;
    @(negedge clk);
    while (!host_cfg_rdy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) expired("push_cfg");
    else exp_cfg.push_back('{a: a, d: d, op: op});
    @(posedge clk); #1;
    host_cfg_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(exp_len.size() == 0 && credits == 0 && exp_cfg.size() == 0 &&
             exp_rsp.size() == 0 && host_len_rdy && host_cfg_rdy) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (n >= limit) expired("wait_idle");
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  bit stop_rand = 1'b0;
  int lens[12];
  int nbytes;
  int r0, f0;

  initial begin
    // ---- reset state, with every ready high so gating is visible
    len_rdy = 1; din_rdy = 1; cfg_rdy = 1; dout_rdy = 1;
    #2 rst = 1'b1;
    step(2);
    chk("rst_len_en", 32'(len_en), 0);
    chk("rst_din_en", 32'(din_en), 0);
    chk("rst_cfg_en", 32'(cfg_en), 0);
    chk("rst_dout_en", 32'(dout_en), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_value", 32'(res_value), 0);
    chk("rst_rsp_valid", 32'(host_rsp_valid), 0);
    chk("rst_rsp_value", host_rsp_value, 0);
    chk("rst_cfg_addr", 32'(cfg_address), 0);
    chk("rst_cfg_data", cfg_data_in, 0);
    chk("rst_byte_rdy", 32'(host_byte_rdy), 1);
    dout_rdy = 0;
    rst = 1'b0;

    // ---- len=3 with bytes pushed first; latency and back-to-back din
    din_cyc.delete(); len_cyc.delete();
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    push_len(8'd3);
    wait_idle(100);
    chk("p3_din_count", 32'(din_cyc.size()), 3);
    chk("p3_len_count", 32'(len_cyc.size()), 1);
    if (din_cyc.size() == 3 && len_cyc.size() == 1) begin
      chk("p3_len_latency", 32'(len_cyc[0] - host_len_edge), 1);
      chk("p3_din_latency", 32'(din_cyc[0] - host_len_edge), 2);
      chk("p3_din_gap1", 32'(din_cyc[1] - din_cyc[0]), 1);
      chk("p3_din_gap2", 32'(din_cyc[2] - din_cyc[1]), 1);
    end
    chk("p3_idle", 32'(host_len_rdy), 1);

    // ---- len=0 with a byte waiting: no din, back to IDLE next cycle
    push_byte(8'h77);
    f0 = din_fires;
    r0 = len_fires;
    push_len(8'd0);
    begin
      int n = 0;
      while (len_fires == r0 && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) expired("p0_len_fire");
    end
    @(negedge clk);
    chk("p0_host_len_rdy", 32'(host_len_rdy), 1);
    step(3);
    chk("p0_no_din", 32'(din_fires - f0), 0);
    push_len(8'd1);
    wait_idle(100);

    // ---- fill FIFO, then a same-cycle push/pop at count 15
    din_rdy = 0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
    @(negedge clk);
    chk("full_byte_rdy", 32'(host_byte_rdy), 0);
    @(posedge clk); #1;
    push_len(8'd2);
    step(2);
    din_rdy = 1;
    step(1);
    din_rdy = 1;
    host_byte_value = 8'hC5;
    host_byte_en = 1;
    @(negedge clk);
    chk("at15_byte_rdy", 32'(host_byte_rdy), 1);
    if (host_byte_rdy) exp_din.push_back(8'hC5);
    @(posedge clk); #1;
    host_byte_en = 0;
    din_rdy = 0;
    @(negedge clk);
    chk("pushpop_keeps_15", 32'(host_byte_rdy), 1);
    @(posedge clk); #1;
    push_byte(8'hC6);
    @(negedge clk);
    chk("refull_byte_rdy", 32'(host_byte_rdy), 0);
    @(posedge clk); #1;
    din_rdy = 1;
    push_len(8'd16);
    wait_idle(200);
    chk("fifo_drained", 32'(exp_din.size()), 0);

    // ---- config write then read
    cfg_rdy = 1;
    cfg_data_out = 32'hDEADBEEF;
    r0 = rsp_seen;
    f0 = cfg_fires;
    push_cfg(8'h04, 32'hDEADBEEF, CFG_WRITE);
    step(4);
    chk("wr_no_rsp", 32'(rsp_seen - r0), 0);
    push_cfg(8'h04, 32'h0, CFG_READ);
    step(4);
    chk("rd_one_rsp", 32'(rsp_seen - r0), 1);
    chk("cfg_fire_count", 32'(cfg_fires - f0), 2);

    // ---- dout capture with back-pressure from res_ack
    res_ack = 1; dout_rdy = 0;
    step(2);
    res_ack = 0; dout_rdy = 1; dout_value = 8'h55;
    f0 = dout_fires;
    step(1);
    dout_value = 8'h66;
    step(3);
    chk("dout_one_capture", 32'(dout_fires - f0), 1);
    chk("dout_held_valid", 32'(res_valid), 1);
    chk("dout_held_value", 32'(res_value), 32'h55);
    chk("dout_en_blocked", 32'(dout_en), 0);
    res_ack = 1;
    step(1);
    res_ack = 0; dout_rdy = 0;
    chk("dout_ack_value", 32'(res_value), 32'h66);
    chk("dout_ack_valid", 32'(res_valid), 1);
    res_ack = 1;
    step(1);
    res_ack = 0;
    chk("dout_cleared", 32'(res_valid), 0);
    chk("res_queue_empty", 32'(exp_res.size()), 0);

    // ---- reset during SEND_DATA with two bytes pending and a cfg in flight
    len_rdy = 1; din_rdy = 0; cfg_rdy = 0;
    push_byte(8'h11); push_byte(8'h22);
    push_len(8'd2);
    push_cfg(8'h10, 32'h1234, CFG_READ);
    step(2);
    rst = 1;
    din_rdy = 1; len_rdy = 1; cfg_rdy = 1; dout_rdy = 1;
    #1;
    chk("mid_rst_len_en", 32'(len_en), 0);
    chk("mid_rst_din_en", 32'(din_en), 0);
    chk("mid_rst_cfg_en", 32'(cfg_en), 0);
    chk("mid_rst_dout_en", 32'(dout_en), 0);
    chk("mid_rst_rsp_valid", 32'(host_rsp_valid), 0);
    exp_len.delete(); exp_din.delete(); exp_cfg.delete(); exp_rsp.delete(); exp_res.delete();
    credits = 0;
    dout_rdy = 0;
    step(2);
    rst = 0;
    @(negedge clk);
    chk("post_rst_len_rdy", 32'(host_len_rdy), 1);
    chk("post_rst_byte_rdy", 32'(host_byte_rdy), 1);
    chk("post_rst_cfg_rdy", 32'(host_cfg_rdy), 1);
    @(posedge clk); #1;
    push_len(8'd1);
    push_byte(8'h3C);
    wait_idle(100);
    chk("post_rst_fifo_empty", 32'(exp_din.size()), 0);

    // ---- randomized concurrent traffic
    nbytes = 0;
    foreach (lens[i]) begin lens[i] = int'($urandom_range(0, 6)); nbytes += lens[i]; end
    fork
      begin
        fork
          foreach (lens[i]) begin
            step(int'($urandom_range(0, 3)));
            push_len(8'(lens[i]));
          end
          for (int i = 0; i < nbytes; i++) begin
            step(int'($urandom_range(0, 2)));
            push_byte(8'($urandom));
          end
          for (int i = 0; i < 10; i++) begin
            step(int'($urandom_range(0, 4)));
            push_cfg(8'($urandom), $urandom, 1'($urandom));
          end
        join
        stop_rand = 1'b1;
      end
      while (!stop_rand) begin
        len_rdy      = ($urandom_range(0, 3) != 0);
        din_rdy      = ($urandom_range(0, 3) != 0);
        cfg_rdy      = ($urandom_range(0, 2) != 0);
        dout_rdy     = 1'($urandom);
        res_ack      = 1'($urandom);
        dout_value   = 8'($urandom);
        cfg_data_out = $urandom;
        step(1);
      end
    join
    len_rdy = 1; din_rdy = 1; cfg_rdy = 1; dout_rdy = 0; res_ack = 1;
    wait_idle(2000);
    step(3);
    chk("rand_din_drained", 32'(exp_din.size()), 0);
    chk("rand_res_drained", 32'(exp_res.size()), 0);
    chk("rand_res_valid", 32'(res_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
